// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//
// Purpose:
//   Write-side initiator for the 32x32 register file. Buffers result
//   writebacks from execute/load units in a small FIFO and issues them one
//   per cycle on the register file write port (WE3/A3/WD3). A forwarding
//   lookup lets read ports A1/A2 see writes that are still pending, so
//   multi-cycle producers can retire without stalling on the write port.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   producer writeback handshake
//   in_rd, in_data      destination register and value
//   wb_hold             suppress draining this cycle (write port borrowed)
//   WE3, A3, WD3        registered register file write port
//   A1, A2              lookup addresses (mirrors of register file read ports)
//   fwd1_hit/fwd1_data  youngest pending value for A1 (0 on miss)
//   fwd2_hit/fwd2_data  youngest pending value for A2 (0 on miss)
//   count               valid FIFO entries (output stage not included)
//   empty               no FIFO entries and no write in flight
//
// Handshake: a transfer happens at a rising edge where in_valid & in_ready
// are both high. in_ready depends only on the queue occupancy (never on
// in_valid), and does not credit a pop in the same cycle, so a full queue
// refuses input even while it drains. A transfer to x0 is accepted and
// dropped.
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       wb_hold,
    output logic                       WE3,
    output logic [AW-1:0]              A3,
    output logic [XLEN-1:0]            WD3,
    input  logic [AW-1:0]              A1,
    input  logic [AW-1:0]              A2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   r_rd_mem   [DEPTH];
    logic [XLEN-1:0] r_data_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_we3;
    logic [AW-1:0]   r_a3;
    logic [XLEN-1:0] r_wd3;

    logic            w_push;
    logic            w_store;
    logic            w_pop;
    logic [XLEN:0]   w_lk1;
    logic [XLEN:0]   w_lk2;

    assign in_ready = reset & (r_count < CW'(DEPTH));
    assign w_push   = in_valid & in_ready;
    // Writes to x0 complete the handshake but never occupy an entry.
    assign w_store  = w_push & (in_rd != '0);
    assign w_pop    = (r_count != '0) & ~wb_hold;

    // Entry storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_rd_mem[r_wr_ptr]   <= in_rd;
            r_data_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_we3    <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_a3     <= r_rd_mem[r_rd_ptr];
                r_wd3    <= r_data_mem[r_rd_ptr];
            end
            // A3/WD3 keep their last value when nothing drains.
            r_we3 <= w_pop;
            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Lookup: the output stage is the oldest candidate, then FIFO entries
    // from oldest to youngest, so later matches overwrite earlier ones and
    // the youngest pending value wins. Returns {hit, data}.
    function automatic logic [XLEN:0] f_lookup(input logic [AW-1:0] addr);
        logic            hit;
        logic [XLEN-1:0] data;
        logic [PW-1:0]   idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (r_we3 && (r_a3 == addr)) begin
            hit  = 1'b1;
            data = r_wd3;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_rd_mem[idx] == addr)) begin
                hit  = 1'b1;
                data = r_data_mem[idx];
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    always_comb begin
        w_lk1 = f_lookup(A1);
        w_lk2 = f_lookup(A2);
    end

    assign fwd1_hit  = w_lk1[XLEN];
    assign fwd1_data = w_lk1[XLEN-1:0];
    assign fwd2_hit  = w_lk2[XLEN];
    assign fwd2_data = w_lk2[XLEN-1:0];

    assign WE3   = r_we3;
    assign A3    = r_a3;
    assign WD3   = r_wd3;
    assign count = r_count;
    assign empty = (r_count == '0) & ~r_we3;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Directed bench for regfile_wb_queue (DEPTH=4, XLEN=32, AW=5). Inputs are
// driven 1 time unit after a rising edge; outputs are observed at that same
// point, i.e. they reflect the state produced by that edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_rd = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            wb_hold = 1'b0;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic [AW-1:0]   A1 = '0;
    logic [AW-1:0]   A2 = '0;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic [2:0]      count;
    logic            empty;

    regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .wb_hold   (wb_hold),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .A1        (A1),
        .A2        (A2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count),
        .empty     (empty)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pulses;
        logic [AW+XLEN-1:0] e;

        // Reset state
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_we3", 64'(WE3), 64'd0);
        check("rst_a3", 64'(A3), 64'd0);
        check("rst_wd3", 64'(WD3), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Single write
        drive_push(5'd5, 32'hDEADBEEF);
        A1 = 5'd5;
        tick();
        drive_idle();
        check("single_queued_count", 64'(count), 64'd1);
        check("single_queued_we3", 64'(WE3), 64'd0);
        check("single_queued_empty", 64'(empty), 64'd0);
        check("single_queued_hit", 64'(fwd1_hit), 64'd1);
        check("single_queued_data", 64'(fwd1_data), 64'hDEADBEEF);
        tick();
        check("single_we3", 64'(WE3), 64'd1);
        check("single_a3", 64'(A3), 64'd5);
        check("single_wd3", 64'(WD3), 64'hDEADBEEF);
        check("single_drain_count", 64'(count), 64'd0);
        check("single_drain_empty", 64'(empty), 64'd0);
        check("single_out_hit", 64'(fwd1_hit), 64'd1);
        check("single_out_data", 64'(fwd1_data), 64'hDEADBEEF);
        tick();
        check("single_done_we3", 64'(WE3), 64'd0);
        check("single_done_a3_hold", 64'(A3), 64'd5);
        check("single_done_hit", 64'(fwd1_hit), 64'd0);
        check("single_done_data", 64'(fwd1_data), 64'd0);
        check("single_done_empty", 64'(empty), 64'd1);

        // Fill / full with hold
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_push(AW'(i), XLEN'(i * 'h11));
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_we3", 64'(WE3), 64'd0);
        drive_push(5'd6, 32'h66);
        A1 = 5'd6;
        A2 = 5'd3;
        tick();
        check("refused_count", 64'(count), 64'd4);
        check("refused_fwd1_hit", 64'(fwd1_hit), 64'd0);
        check("full_fwd2_hit", 64'(fwd2_hit), 64'd1);
        check("full_fwd2_data", 64'(fwd2_data), 64'h33);
        drive_idle();
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_we3", 64'(WE3), 64'd1);
            check("drain_a3", 64'(A3), 64'(i));
            check("drain_wd3", 64'(WD3), 64'(i * 'h11));
            check("drain_count", 64'(count), 64'(4 - i));
        end
        tick();
        check("drain_done_we3", 64'(WE3), 64'd0);
        check("drain_done_empty", 64'(empty), 64'd1);

        // Forward priority: younger FIFO entry beats older entry and output stage
        wb_hold = 1'b1;
        drive_push(5'd7, 32'h100);
        tick();
        drive_push(5'd7, 32'h200);
        tick();
        drive_idle();
        A1 = 5'd7;
        A2 = 5'd7;
        #1;
        check("prio_fwd1_hit", 64'(fwd1_hit), 64'd1);
        check("prio_fwd1_data", 64'(fwd1_data), 64'h200);
        check("prio_fwd2_data", 64'(fwd2_data), 64'h200);
        wb_hold = 1'b0;
        tick();
        check("prio_pop1_wd3", 64'(WD3), 64'h100);
        check("prio_pop1_fwd1", 64'(fwd1_data), 64'h200);
        check("prio_pop1_fwd2", 64'(fwd2_data), 64'h200);
        tick();
        check("prio_pop2_wd3", 64'(WD3), 64'h200);
        check("prio_pop2_fwd1", 64'(fwd1_data), 64'h200);
        tick();
        check("prio_done_hit", 64'(fwd1_hit), 64'd0);

        // x0 writes are accepted and dropped
        drive_push(5'd0, 32'hFFFFFFFF);
        A1 = 5'd0;
        #1;
        check("x0_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive_idle();
        check("x0_count", 64'(count), 64'd0);
        check("x0_we3", 64'(WE3), 64'd0);
        check("x0_hit", 64'(fwd1_hit), 64'd0);
        tick();
        check("x0_we3_later", 64'(WE3), 64'd0);
        check("x0_empty", 64'(empty), 64'd1);

        // Streaming with pointer wrap
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 10) begin
                drive_push(AW'(k + 10), XLEN'(32'h1000 + k));
                exp_q.push_back({AW'(k + 10), XLEN'(32'h1000 + k)});
            end else begin
                drive_idle();
            end
            tick();
            check("stream_count_le1", 64'(count <= 3'd1), 64'd1);
            if (WE3) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_we3", 64'(WE3), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_a3", 64'(A3), 64'(e[AW+XLEN-1:XLEN]));
                    check("stream_wd3", 64'(WD3), 64'(e[XLEN-1:0]));
                end
            end
        end
        check("stream_pulses", 64'(pulses), 64'd10);
        check("stream_exp_left", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-drain
        wb_hold = 1'b1;
        drive_push(5'd9, 32'hA1);
        tick();
        drive_push(5'd10, 32'hA2);
        tick();
        drive_push(5'd11, 32'hA3);
        tick();
        drive_idle();
        wb_hold = 1'b0;
        tick();
        A1 = 5'd11;
        #1;
        check("pre_rst_we3", 64'(WE3), 64'd1);
        check("pre_rst_count", 64'(count), 64'd2);
        check("pre_rst_hit", 64'(fwd1_hit), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_we3", 64'(WE3), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_hit", 64'(fwd1_hit), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("post_arst_we3", 64'(WE3), 64'd0);
        check("post_arst_count", 64'(count), 64'd0);
        check("post_arst_in_ready", 64'(in_ready), 64'd1);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
